// File: rtl/lsu_bus_adapter_if.sv
// Core-side and memory-side bundles for the load/store bus adapter.
// The adapter is the slave of the core bundle and the master of the memory bundle.

interface lsu_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;

  modport master (
    output mem_req, mem_we, funct3, addr, wdata,
    input  rdata, stall, fault
  );

  modport slave (
    input  mem_req, mem_we, funct3, addr, wdata,
    output rdata, stall, fault
  );
endinterface

interface lsu_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_adapter.sv
// Load/store adapter: turns single-cycle core data accesses into sized, lane-steered
// requests on a variable-latency word bus, stalling the core until each completes.

module lsu_bus_adapter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  lsu_core_if.slave core,
  lsu_bus_if.master bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  generate
    if (TIMEOUT < 1 || TIMEOUT > 255 || (TIMEOUT >> CW) != 0) begin : g_bad_param
      $error("lsu_bus_adapter: TIMEOUT must be 1..255 and fit in CW bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            fault_q, fault_d;

  logic            bad_f3_c;
  logic            misaligned_c;
  logic            legal_c;
  logic [BW-1:0]   lane_be_c;
  logic [DW-1:0]   lane_wdata_c;
  logic [DW-1:0]   shifted_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [DW-1:0]   load_val_c;

  // Access legality, judged on the live request fields while idle
  always_comb begin
    bad_f3_c     = 1'b0;
    misaligned_c = 1'b0;
    if (core.mem_we) begin
      bad_f3_c = (core.funct3 >= 3'b011);
    end else begin
      bad_f3_c = (core.funct3 == 3'b011) || (core.funct3[2:1] == 2'b11);
    end
    if (core.funct3[1:0] == 2'b01 && core.addr[0]) begin
      misaligned_c = 1'b1;
    end
    if (core.funct3[1:0] == 2'b10 && core.addr[1:0] != 2'b00) begin
      misaligned_c = 1'b1;
    end
    legal_c = !bad_f3_c && !misaligned_c;
  end

  // Store lane steering; loads read the whole word
  always_comb begin
    lane_be_c    = {BW{1'b1}};
    lane_wdata_c = '0;
    if (core.mem_we) begin
      unique case (core.funct3[1:0])
        2'b00: begin
          lane_be_c    = BW'(4'b0001 << core.addr[1:0]);
          lane_wdata_c = {4{core.wdata[7:0]}};
        end
        2'b01: begin
          lane_be_c    = BW'(4'b0011 << core.addr[1:0]);
          lane_wdata_c = {2{core.wdata[15:0]}};
        end
        default: begin
          lane_be_c    = {BW{1'b1}};
          lane_wdata_c = core.wdata;
        end
      endcase
    end
  end

  // Load extraction and extension from the returned word
  always_comb begin
    shifted_c = bus.bus_rdata >> {off_q, 3'b000};
    byte_c    = shifted_c[7:0];
    half_c    = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    unique case (f3_q)
      3'b000:  load_val_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_val_c = {24'h000000, byte_c};
      3'b001:  load_val_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_val_c = {16'h0000, half_c};
      default: load_val_c = bus.bus_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;

    unique case (state_q)
      S_IDLE: begin
        if (core.mem_req) begin
          if (legal_c) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            f3_d    = core.funct3;
            off_d   = core.addr[1:0];
            req_d   = 1'b1;
            we_d    = core.mem_we;
            addr_d  = {core.addr[31:2], 2'b00};
            be_d    = lane_be_c;
            wdata_d = lane_wdata_c;
          end else begin
            state_d = S_DONE;
            rdata_d = '0;
            fault_d = 1'b1;
          end
        end
      end

      S_BUSY: begin
        if (bus.bus_ack || cnt_q == CW'(TIMEOUT)) begin
          // An ack on the final allowed cycle still counts as success
          state_d = S_DONE;
          fault_d = !bus.bus_ack;
          rdata_d = (bus.bus_ack && !we_q) ? load_val_c : '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        rdata_d = '0;
        fault_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Stall is combinational so the core freezes in the same cycle it issues
  assign core.stall = reset_n & core.mem_req & (state_q != S_DONE);
  assign core.rdata = rdata_q;
  assign core.fault = fault_q;

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Scoreboard bench for lsu_bus_adapter: expected completions are queued at issue
// and compared when the core sees stall drop.

module tb_lsu_bus_adapter;

  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lsu_core_if core ();
  lsu_bus_if  bus ();

  lsu_bus_adapter #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .core    (core),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic bad_f3, mis;
    if (we) bad_f3 = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    bad_f3 = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
    return bad_f3 || mis;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!we) return 4'hF;
    case (f3)
      3'd0: case (a[1:0])
              2'd0: return 4'h1;
              2'd1: return 4'h2;
              2'd2: return 4'h4;
              default: return 4'h8;
            endcase
      3'd1: return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic we, input logic [2:0] f3, input logic [31:0] wd);
    if (!we) return 32'h0;
    case (f3)
      3'd0: return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      3'd1: return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd4: return {24'h0, b};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  // One core instruction; waits > TIMEOUT means the memory never acks
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int waits);
    exp_t e, got;
    logic bad, done, saw_req;
    int stalls, busy;
    bad     = is_illegal(we, f3, a);
    e.fault = bad || (waits > int'(TIMEOUT));
    e.rdata = (e.fault || we) ? 32'h0 : exp_load(f3, a, rd);
    e.stalls = bad ? 1 : ((waits > int'(TIMEOUT)) ? int'(TIMEOUT) + 2 : waits + 2);
    done = 1'b0; saw_req = 1'b0; stalls = 0; busy = 0;

    @(negedge clk);
    core.mem_req = 1'b1;
    core.mem_we  = we;
    core.funct3  = f3;
    core.addr    = a;
    core.wdata   = wd;
    bus.bus_ack  = 1'b0;
    sb.push_back(e);
    #1;
    check_eq({tag, "_idle_rdata"}, core.rdata, 32'h0);
    check_eq({tag, "_idle_fault"}, 32'(core.fault), 32'h0);

    for (int c = 0; c < 64 && !done; c++) begin
      if (!core.stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (bus.bus_req) begin
          saw_req = 1'b1;
          check_eq({tag, "_bus_addr"}, bus.bus_addr, {a[31:2], 2'b00});
          check_eq({tag, "_bus_be"}, 32'(bus.bus_be), 32'(exp_be(we, f3, a)));
          check_eq({tag, "_bus_wdata"}, bus.bus_wdata, exp_wdata(we, f3, wd));
          check_eq({tag, "_bus_we"}, 32'(bus.bus_we), 32'(we));
          bus.bus_ack   = (busy == waits);
          bus.bus_rdata = rd;
          busy++;
        end else begin
          bus.bus_ack = 1'b0;
        end
        @(negedge clk);
        #1;
      end
    end
    bus.bus_ack = 1'b0;

    check_eq({tag, "_done_seen"}, 32'(done), 32'h1);
    check_eq({tag, "_bus_req_used"}, 32'(saw_req), 32'(!bad));
    got = sb.pop_front();
    check_eq({tag, "_rdata"}, core.rdata, got.rdata);
    check_eq({tag, "_fault"}, 32'(core.fault), 32'(got.fault));
    check_eq({tag, "_stall_cycles"}, 32'(stalls), 32'(got.stalls));
    core.mem_req = 1'b0;
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  load_f3 [5];
    load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    reset_n        = 1'b0;
    core.mem_req   = 1'b1;
    core.mem_we    = 1'b0;
    core.funct3    = 3'd2;
    core.addr      = 32'h0;
    core.wdata     = 32'h0;
    bus.bus_ack    = 1'b0;
    bus.bus_rdata  = 32'h0;
    #2;
    check_eq("rst_bus_req", 32'(bus.bus_req), 32'h0);
    check_eq("rst_stall", 32'(core.stall), 32'h0);
    check_eq("rst_rdata", core.rdata, 32'h0);
    check_eq("rst_bus_be", 32'(bus.bus_be), 32'h0);
    @(negedge clk);
    core.mem_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    access("sw",        1'b1, 3'd2, 32'h0000_0064, 32'h0000_0019, 32'h0, 0);
    access("lb",        1'b0, 3'd0, 32'h0000_0063, 32'h0, 32'h80FF_0000, 0);
    access("lbu",       1'b0, 3'd4, 32'h0000_0063, 32'h0, 32'h80FF_0000, 0);
    access("sh",        1'b1, 3'd1, 32'h0000_0066, 32'h0000_BEEF, 32'h0, 0);
    access("sh_mis",    1'b1, 3'd1, 32'h0000_0065, 32'h0000_BEEF, 32'h0, 0);
    access("lw_wait3",  1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h1234_5678, 3);
    access("lw_tmo",    1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 99);
    access("lw_lastack",1'b0, 3'd2, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, int'(TIMEOUT));
    access("lh_hi",     1'b0, 3'd1, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 1);
    access("lhu_hi",    1'b0, 3'd5, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 0);
    access("lh_lo",     1'b0, 3'd1, 32'h0000_0040, 32'h0, 32'h8001_7FFF, 0);
    access("sb_off1",   1'b1, 3'd0, 32'h0000_0061, 32'h0000_00A5, 32'h0, 2);
    access("ld_f3_011", 1'b0, 3'd3, 32'h0000_0040, 32'h0, 32'h0, 0);
    access("st_f3_100", 1'b1, 3'd4, 32'h0000_0040, 32'h1, 32'h0, 0);
    access("lw_mis",    1'b0, 3'd2, 32'h0000_0042, 32'h0, 32'h0, 0);

    // Reset in the second BUSY cycle
    @(negedge clk);
    core.mem_req = 1'b1; core.mem_we = 1'b0; core.funct3 = 3'd2; core.addr = 32'h40;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_bus_req", 32'(bus.bus_req), 32'h0);
    check_eq("midrst_stall", 32'(core.stall), 32'h0);
    check_eq("midrst_bus_addr", bus.bus_addr, 32'h0);
    check_eq("midrst_bus_be", 32'(bus.bus_be), 32'h0);
    check_eq("midrst_fault", 32'(core.fault), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    core.mem_req = 1'b0;
    bus.bus_ack = 1'b1;
    bus.bus_rdata = 32'hFFFF_FFFF;
    #1;
    @(negedge clk);
    #1;
    check_eq("stray_ack_bus_req", 32'(bus.bus_req), 32'h0);
    check_eq("stray_ack_rdata", core.rdata, 32'h0);
    check_eq("stray_ack_fault", 32'(core.fault), 32'h0);
    bus.bus_ack = 1'b0;
    access("post_rst_lw", 1'b0, 3'd2, 32'h0000_0080, 32'h0, 32'h0BAD_CAFE, 0);

    for (int i = 0; i < 10; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
      a  = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3 == 3'd2) a[1:0] = 2'b00;
      access("rnd", we, f3, a, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Load/store unit between the single-cycle core's data port (ALUResult/WriteData/MemWrite) and a variable-latency data memory bus.
- Adds byte/halfword access, sign/zero extension, misalignment detection and a bus timeout.
- Stalls the core (core holds PC and disables the register write while stall=1) until each access completes.

Parameters:
- TIMEOUT, 15, max BUSY cycles without bus_ack before abort (1..255)
- CW, 8, width of the wait counter; must satisfy 2**CW > TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_req  in  1  core requests a load/store this instruction; fields held stable while stall=1
- mem_we  in  1  1=store, 0=load
- funct3  in  3  instruction funct3: size/sign
- addr  in  32  byte address (ALUResult)
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load result, valid in DONE
- stall  out  1  core must not advance
- fault  out  1  misaligned/illegal-funct3/timeout, valid in DONE
- bus_req  out  1  registered bus request
- bus_we  out  1  registered bus write
- bus_addr  out  32  {addr[31:2],2'b00}, registered
- bus_be  out  4  byte enables, registered
- bus_wdata  out  32  lane-replicated store data, registered
- bus_ack  in  1  completion; sampled only when bus_req=1
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0; all outputs 0 (bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata, fault, stall). Takes effect immediately, including mid-access; bus_req drops without waiting for ack.
- States: IDLE, BUSY, DONE.
- stall = mem_req & (state != DONE), combinational.
- IDLE:
  - mem_req=0: stay.
  - mem_req=1 and access legal: latch bus_* fields and load funct3/addr[1:0]; go BUSY; counter=0.
  - mem_req=1 and access illegal: go DONE with fault=1, rdata=0; no bus_req.
- Illegal access:
  - Loads: funct3 011, 110, 111 illegal. Stores: funct3 >= 011 illegal.
  - Misaligned: half (x01) with addr[0]=1; word (010) with addr[1:0]!=00.
- BUSY:
  - bus_req=1, all bus_* outputs held stable.
  - bus_ack=1: capture extended data into rdata (stores: rdata=0); go DONE; bus_req=0 next cycle.
  - Otherwise: counter+1. When counter==TIMEOUT with no ack: go DONE, fault=1, rdata=0.
  - An ack in the same cycle as counter==TIMEOUT wins (no fault).
- DONE:
  - stall=0, rdata/fault valid for exactly this cycle.
  - Always go IDLE next; rdata and fault clear to 0 on leaving DONE.
  - A new mem_req in DONE is the next instruction only after this edge, i.e. it is seen in IDLE.
- Latency: zero-wait bus gives 3 cycles per access (IDLE, BUSY, DONE). Each bus wait cycle adds 1.
- Store lanes, with off=addr[1:0]:
  - sb: be=4'b0001<<off; wdata={4{wdata[7:0]}}.
  - sh: be=4'b0011<<off; wdata={2{wdata[15:0]}}.
  - sw: be=4'b1111; wdata unchanged.
  - Loads: be=4'b1111, bus_wdata=0.
- Load extraction from bus_rdata:
  - lb/lbu: byte at off, sign-/zero-extended.
  - lh/lhu: half at off[1], sign-/zero-extended.
  - lw: full word.
- bus_ack while bus_req=0 is ignored.

Test Plan:
- sw addr=0x64 wdata=0x19, ack in first BUSY cycle -> bus_be=1111, bus_addr=0x64, bus_wdata=0x19; stall high 2 cycles; DONE in cycle 3; fault=0.
- lb addr=0x63, bus_rdata=0x80FF_0000 -> bus_addr=0x60, rdata=0xFFFF_FF80; lbu same access -> rdata=0x0000_0080.
- sh addr=0x66 wdata=0x0000_BEEF -> bus_be=1100, bus_wdata=0xBEEF_BEEF. sh addr=0x65 -> no bus_req, DONE next cycle with fault=1, rdata=0.
- lw addr=0x40, ack after 3 wait cycles, bus_rdata=0x1234_5678 -> bus_* stable throughout; stall for 5 cycles; rdata=0x1234_5678 in DONE.
- lw with bus_ack held 0, TIMEOUT=15 -> after 16 BUSY cycles enter DONE with fault=1, rdata=0. Variant with ack on that final cycle -> fault=0, data captured.
- reset_n pulsed low in the 2nd BUSY cycle -> bus_req, stall and all outputs 0 immediately; after release state=IDLE; a stray bus_ack is ignored.
